// File: rtl/op_fetch_seq.sv
// Microcode fetch/decode sequencer feeding the 4-bit operand register.
// Define ILLEGAL_TRAP_EN to trap opcodes 0x4..0xE (halt + sticky err); otherwise they act as NOP.
module op_fetch_seq #(
  parameter int unsigned PC_W   = 4,
  parameter int unsigned RST_PC = 0
) (
  input  logic            clk,
  input  logic            grst,
  input  logic            start,
  input  logic            mem_rdy,
  input  logic [3:0]      bus,
  output logic [PC_W-1:0] pc,
  output logic            mem_oe,
  output logic [3:0]      imm,
  output logic            rs5,
  output logic            ws3,
  output logic            busy,
  output logic            halted,
  output logic            err
);

  typedef enum logic [1:0] {StIdle, StFOp, StFImm, StExec} state_e;

  localparam logic [PC_W-1:0] RstPc = RST_PC[PC_W-1:0];
  localparam logic [PC_W-1:0] PcOne = {{(PC_W-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      opcode_q, opcode_d;
  logic [3:0]      imm_q, imm_d;
  logic            halted_q, halted_d;
  logic            err_q, err_d;
  logic            rs5_q, rs5_d;
  logic            ws3_q, ws3_d;
  logic            mem_oe_q, mem_oe_d;
  logic            busy_q, busy_d;
  logic [PC_W+3:0] imm_ext;

  // Zero-extend then truncate so the jump target works for any PC_W.
  assign imm_ext = {{PC_W{1'b0}}, imm_q};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    halted_d = halted_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StFOp;
          halted_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      StFOp: begin
        if (mem_rdy) begin
          opcode_d = bus;
          pc_d     = pc_q + PcOne;
          state_d  = StFImm;
        end
      end
      StFImm: begin
        if (mem_rdy) begin
          imm_d   = bus;
          pc_d    = pc_q + PcOne;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFOp;
        case (opcode_q)
          4'h0, 4'h1, 4'h2: ;
          4'h3: pc_d = imm_ext[PC_W-1:0];
          4'hF: begin
            state_d  = StIdle;
            halted_d = 1'b1;
          end
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d  = StIdle;
            halted_d = 1'b1;
            err_d    = 1'b1;
`endif
          end
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so they align exactly with the EXEC cycle.
  always_comb begin
    rs5_d    = (state_d == StExec) && (opcode_d == 4'h1);
    ws3_d    = (state_d == StExec) && (opcode_d == 4'h2);
    mem_oe_d = (state_d == StFOp) || (state_d == StFImm);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (grst) begin
      state_q  <= StIdle;
      pc_q     <= RstPc;
      opcode_q <= 4'h0;
      imm_q    <= 4'h0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      rs5_q    <= 1'b0;
      ws3_q    <= 1'b0;
      mem_oe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      rs5_q    <= rs5_d;
      ws3_q    <= ws3_d;
      mem_oe_q <= mem_oe_d;
      busy_q   <= busy_d;
    end
  end

  assign pc     = pc_q;
  assign imm    = imm_q;
  assign rs5    = rs5_q;
  assign ws3    = ws3_q;
  assign mem_oe = mem_oe_q;
  assign busy   = busy_q;
  assign halted = halted_q;
  assign err    = err_q;

endmodule

// File: tb/tb_op_fetch_seq.sv
// Directed self-checking bench for op_fetch_seq with a 16-nibble program memory model.
module tb_op_fetch_seq;

  logic       clk = 1'b0;
  logic       grst, start, mem_rdy;
  logic [3:0] bus;
  logic [3:0] pc;
  logic       mem_oe, rs5, ws3, busy, halted, err;
  logic [3:0] imm;
  logic [3:0] mem [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign bus = mem_oe ? mem[pc] : 4'h0;

  op_fetch_seq #(.PC_W(4), .RST_PC(0)) dut (
    .clk     (clk),
    .grst    (grst),
    .start   (start),
    .mem_rdy (mem_rdy),
    .bus     (bus),
    .pc      (pc),
    .mem_oe  (mem_oe),
    .imm     (imm),
    .rs5     (rs5),
    .ws3     (ws3),
    .busy    (busy),
    .halted  (halted),
    .err     (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
  endtask

  task automatic do_reset();
    grst = 1'b1; start = 1'b0; mem_rdy = 1'b1;
    step();
    grst = 1'b0;
  endtask

  // Pulse start for one edge; leaves the DUT in F_OP.
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    grst = 1'b1; start = 1'b0; mem_rdy = 1'b1;
    clear_mem();

    // Reset state
    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_imm", imm, 0);
    chk("rst_strobes", {rs5, ws3, mem_oe}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);

    // 1: LDI 5 then HLT
    mem[0] = 4'h1; mem[1] = 4'h5; mem[2] = 4'hF; mem[3] = 4'h0;
    kick();
    chk("t1_fop_oe", mem_oe, 1);
    chk("t1_fop_busy", busy, 1);
    step();
    chk("t1_fimm_pc", pc, 1);
    chk("t1_fimm_rs5", rs5, 0);
    step();
    chk("t1_exec_rs5", rs5, 1);
    chk("t1_exec_ws3", ws3, 0);
    chk("t1_exec_imm", imm, 5);
    chk("t1_exec_pc", pc, 2);
    chk("t1_exec_oe", mem_oe, 0);
    step();
    chk("t1_rs5_drop", rs5, 0);
    chk("t1_imm_hold", imm, 5);
    step(); step(); step();
    chk("t1_halted", halted, 1);
    chk("t1_idle_busy", busy, 0);
    chk("t1_halt_pc", pc, 4);

    // 2: same program, 2 stall cycles in F_IMM
    do_reset();
    kick();
    step();
    mem_rdy = 1'b0;
    step();
    chk("t2_stall1_oe", mem_oe, 1);
    chk("t2_stall1_pc", pc, 1);
    chk("t2_stall1_rs5", rs5, 0);
    step();
    chk("t2_stall2_pc", pc, 1);
    chk("t2_stall2_rs5", rs5, 0);
    mem_rdy = 1'b1;
    step();
    chk("t2_exec_rs5", rs5, 1);
    chk("t2_exec_pc", pc, 2);

    // 3: JMP 0xA, HLT at 0xA, restart clears halted
    clear_mem();
    mem[0] = 4'h3; mem[1] = 4'hA; mem[10] = 4'hF; mem[11] = 4'h0;
    do_reset();
    kick();
    step(); step();
    chk("t3_exec_pc", pc, 2);
    step();
    chk("t3_jmp_pc", pc, 4'hA);
    chk("t3_jmp_oe", mem_oe, 1);
    step(); step(); step();
    chk("t3_halted", halted, 1);
    chk("t3_busy", busy, 0);
    chk("t3_halt_pc", pc, 4'hC);
    kick();
    chk("t3_restart_halted", halted, 0);
    chk("t3_restart_busy", busy, 1);

    // 4: all NOPs, pc wraps through 0xF
    clear_mem();
    do_reset();
    kick();
    for (int i = 0; i < 23; i++) step();
    chk("t4_wrap_pc", pc, 0);
    chk("t4_wrap_exec_oe", mem_oe, 0);
    chk("t4_wrap_busy", busy, 1);
    step();
    chk("t4_refetch_oe", mem_oe, 1);
    chk("t4_refetch_pc", pc, 0);
    step();
    chk("t4_next_pc", pc, 1);

    // 5: OUT with grst in EXEC
    clear_mem();
    mem[0] = 4'h2; mem[1] = 4'h9;
    do_reset();
    kick();
    step(); step();
    chk("t5_exec_ws3", ws3, 1);
    chk("t5_exec_rs5", rs5, 0);
    chk("t5_exec_imm", imm, 9);
    grst = 1'b1;
    step();
    grst = 1'b0;
    chk("t5_rst_ws3", ws3, 0);
    chk("t5_rst_pc", pc, 0);
    chk("t5_rst_imm", imm, 0);
    chk("t5_rst_busy", busy, 0);

    // 6: illegal opcode 0x7
    clear_mem();
    mem[0] = 4'h7; mem[1] = 4'h3; mem[2] = 4'hF;
    do_reset();
    kick();
    step(); step();
    chk("t6_exec_strobes", {rs5, ws3}, 0);
    step();
`ifdef ILLEGAL_TRAP_EN
    chk("t6_err", err, 1);
    chk("t6_halted", halted, 1);
    chk("t6_pc", pc, 2);
    chk("t6_busy", busy, 0);
`else
    chk("t6_err", err, 0);
    chk("t6_halted", halted, 0);
    chk("t6_pc", pc, 2);
    chk("t6_refetch_oe", mem_oe, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
